// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - shared constants and FSM state type for the JTAG shift master
package jtag_master_pkg;

  localparam logic [1:0] ADDR_TMS  = 2'd0;
  localparam logic [1:0] ADDR_TDI  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_TDO  = 2'd3;

  localparam int LEN_W = 6;

  localparam int STATUS_BUSY_BIT   = 0;
  localparam int STATUS_DONE_BIT   = 1;
  localparam int STATUS_IRQ_EN_BIT = 8;
  localparam int CTRL_IRQ_EN_BIT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } jtag_state_t;

endpackage

// File: rtl/jtag_tck_divider.sv
// rtl/jtag_tck_divider.sv - TCK half-period counter with first/last cycle strikes
module jtag_tck_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic phase_first,
  output logic phase_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign phase_first = run && (cnt == '0);
  assign phase_end   = run && (cnt == CNT_LAST);

  // Count clk cycles within the current half-period, restarting at each phase boundary.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= phase_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_shift_master.sv
// rtl/jtag_shift_master.sv - Avalon-MM JTAG initiator; JTAG_IRQ_EN adds the irq output
module jtag_shift_master
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  input  logic        jtag_tdo
`ifdef JTAG_IRQ_EN
  ,
  output logic        irq
`endif
);

  jtag_state_t state, state_next;

  logic [31:0]      tms_reg, tdi_reg, tdo_reg;
  logic [LEN_W-1:0] len_q;
  logic [4:0]       idx;
  logic [4:0]       idx_next;
  logic             done;
  logic             tck_q, tms_q, tdi_q;
  logic             irq_en;
  logic             busy;
  logic             phase_first, phase_end;
  logic [LEN_W-1:0] wr_len;
  logic             ctrl_wr, start, last_bit, burst_end;
  logic [31:0]      status;

  assign busy      = (state != ST_IDLE);
  assign wr_len    = avs_writedata[LEN_W-1:0];
  assign ctrl_wr   = avs_write && (avs_address == ADDR_CTRL);
  assign start     = ctrl_wr && !busy && (wr_len != '0) && (wr_len <= LEN_W'(MAX_BITS));
  assign last_bit  = ({1'b0, idx} == (len_q - LEN_W'(1)));
  assign idx_next  = idx + 5'd1;
  assign burst_end = (state == ST_HIGH) && phase_end && last_bit;

  assign jtag_tck = tck_q;
  assign jtag_tms = tms_q;
  assign jtag_tdi = tdi_q;

  jtag_tck_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk        (clk_clk),
    .reset      (reset_reset),
    .clear      (start),
    .run        (busy),
    .phase_first(phase_first),
    .phase_end  (phase_end)
  );

  // FSM state register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_next;
  end

  // Next-state: each bit is one LOW half-period followed by one HIGH half-period.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_LOW;
      ST_LOW:  if (phase_end) state_next = ST_HIGH;
      ST_HIGH: if (phase_end) state_next = last_bit ? ST_IDLE : ST_LOW;
      default: state_next = ST_IDLE;
    endcase
  end

  // Register file, pin drivers and TDO capture; new TMS/TDI bits are launched only on entry to LOW.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tms_reg <= '0;
      tdi_reg <= '0;
      tdo_reg <= '0;
      len_q   <= '0;
      idx     <= '0;
      done    <= 1'b0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      if (avs_write && !busy && avs_address == ADDR_TMS) tms_reg <= avs_writedata;
      if (avs_write && !busy && avs_address == ADDR_TDI) tdi_reg <= avs_writedata;
      if ((avs_write || avs_read) && avs_address == ADDR_CTRL) done <= 1'b0;
      if (burst_end) done <= 1'b1;
      if (start) begin
        tdo_reg <= '0;
        len_q   <= wr_len;
        idx     <= '0;
        tms_q   <= tms_reg[0];
        tdi_q   <= tdi_reg[0];
      end
      if (state == ST_LOW && phase_end) tck_q <= 1'b1;
      if (state == ST_HIGH && phase_first) tdo_reg[idx] <= jtag_tdo;
      if (state == ST_HIGH && phase_end) begin
        tck_q <= 1'b0;
        if (!last_bit) begin
          idx   <= idx_next;
          tms_q <= tms_reg[idx_next];
          tdi_q <= tdi_reg[idx_next];
        end
      end
    end
  end

`ifdef JTAG_IRQ_EN
  // Interrupt enable is a plain control bit, accepted even mid-burst.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)  irq_en <= 1'b0;
    else if (ctrl_wr) irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
  end

  assign irq = done & irq_en;
`else
  assign irq_en = 1'b0;
`endif

  // Assemble the STATUS word.
  always_comb begin
    status = '0;
    status[STATUS_BUSY_BIT]   = busy;
    status[STATUS_DONE_BIT]   = done;
    status[STATUS_IRQ_EN_BIT] = irq_en;
  end

  // Read data is registered from pre-edge register values, giving a fixed latency of one cycle.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_TMS:  avs_readdata <= tms_reg;
        ADDR_TDI:  avs_readdata <= tdi_reg;
        ADDR_CTRL: avs_readdata <= status;
        default:   avs_readdata <= tdo_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// tb/tb_jtag_shift_master.sv - directed self-checking bench for jtag_shift_master (JTAG_IRQ_EN optional)
module tb_jtag_shift_master;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
`ifdef JTAG_IRQ_EN
  logic        irq;
`endif

  logic        loopback = 1'b0;
  logic        tdo_fixed = 1'b1;
  assign jtag_tdo = loopback ? jtag_tdi : tdo_fixed;

  int          n_checks = 0;
  int          n_fail = 0;
  int          rise_count = 0;
  logic [31:0] tms_vec = '0;
  logic [31:0] tdi_vec = '0;
  logic        tck_prev = 1'b0;
  logic [31:0] rd;

  jtag_shift_master #(.CLK_DIV(4), .MAX_BITS(32)) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .jtag_tck     (jtag_tck),
    .jtag_tms     (jtag_tms),
    .jtag_tdi     (jtag_tdi),
    .jtag_tdo     (jtag_tdo)
`ifdef JTAG_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  always #5 clk_clk = ~clk_clk;

  // Record TMS/TDI as seen by the target at every TCK rise.
  always @(negedge clk_clk) begin
    if (jtag_tck && !tck_prev) begin
      if (rise_count < 32) begin
        tms_vec[rise_count] = jtag_tms;
        tdi_vec[rise_count] = jtag_tdi;
      end
      rise_count = rise_count + 1;
    end
    tck_prev = jtag_tck;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(posedge clk_clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk_clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic clr_mon();
    rise_count = 0; tms_vec = '0; tdi_vec = '0;
  endtask

  initial begin
    // 1: reset values
    wait_cycles(3);
    check_eq("rst_tck", {31'b0, jtag_tck}, 32'h0);
    check_eq("rst_tms", {31'b0, jtag_tms}, 32'h1);
    check_eq("rst_tdi", {31'b0, jtag_tdi}, 32'h0);
    check_eq("rst_readdata", avs_readdata, 32'h0);
    reset_reset = 1'b0;
    bus_read(2'd2, rd); check_eq("rst_status", rd, 32'h0);
    bus_read(2'd3, rd); check_eq("rst_tdo", rd, 32'h0);

    // simultaneous read/write returns the old value
    avs_address = 2'd0; avs_writedata = 32'h1F; avs_write = 1'b1; avs_read = 1'b1;
    @(posedge clk_clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    check_eq("rw_same_addr_old", avs_readdata, 32'h0);
    bus_read(2'd0, rd); check_eq("tms_readback", rd, 32'h1F);

    // 2: TMS=0x1F, TDI=0, LEN=5, tdo tied 1
    bus_write(2'd1, 32'h0);
    clr_mon();
    tdo_fixed = 1'b1; loopback = 1'b0;
    bus_write(2'd2, 32'd5);
    wait_cycles(39);
    bus_read(2'd2, rd); check_eq("t2_busy_last_cycle", rd, 32'h1);
    bus_read(2'd2, rd); check_eq("t2_status_done", rd, 32'h2);
    check_eq("t2_tck_pulses", rise_count, 32'd5);
    check_eq("t2_tms_at_rise", tms_vec, 32'h1F);
    check_eq("t2_idle_tck", {31'b0, jtag_tck}, 32'h0);
    bus_read(2'd3, rd); check_eq("t2_tdo", rd, 32'h1F);

    // 3: loopback, 32 bits
    loopback = 1'b1;
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'hA5A5_3C3C);
    clr_mon();
    bus_write(2'd2, 32'd32);
    wait_cycles(262);
    check_eq("t3_tck_pulses", rise_count, 32'd32);
    check_eq("t3_tdi_at_rise", tdi_vec, 32'hA5A5_3C3C);
    check_eq("t3_tms_at_rise", tms_vec, 32'h0);
    bus_read(2'd3, rd); check_eq("t3_tdo", rd, 32'hA5A5_3C3C);
    bus_read(2'd2, rd); check_eq("t3_status_done", rd, 32'h2);
    bus_read(2'd2, rd); check_eq("t3_done_cleared", rd, 32'h0);

    // 4: writes during busy are dropped; invalid lengths ignored
    bus_write(2'd1, 32'h5);
    clr_mon();
    bus_write(2'd2, 32'd4);
    wait_cycles(5);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'd8);
    wait_cycles(40);
    check_eq("t4_tck_pulses", rise_count, 32'd4);
    bus_read(2'd3, rd); check_eq("t4_tdo", rd, 32'h5);
    bus_read(2'd1, rd); check_eq("t4_tdi_kept", rd, 32'h5);
    bus_read(2'd2, rd); check_eq("t4_status_done", rd, 32'h2);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rd); check_eq("t4_len0_idle", rd, 32'h0);
    bus_write(2'd2, 32'd33);
    bus_read(2'd2, rd); check_eq("t4_len33_idle", rd, 32'h0);
    wait_cycles(20);
    check_eq("t4_no_extra_tck", rise_count, 32'd4);

    // 5: reset during bit 3 of a 16-bit burst
    loopback = 1'b0; tdo_fixed = 1'b1;
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h0000_FFFF);
    clr_mon();
    bus_write(2'd2, 32'd16);
    wait_cycles(26);
    check_eq("t5_rises_before_reset", rise_count, 32'd3);
    reset_reset = 1'b1;
    wait_cycles(1);
    check_eq("t5_tck", {31'b0, jtag_tck}, 32'h0);
    check_eq("t5_tms", {31'b0, jtag_tms}, 32'h1);
    check_eq("t5_tdi", {31'b0, jtag_tdi}, 32'h0);
    reset_reset = 1'b0;
    bus_read(2'd2, rd); check_eq("t5_status", rd, 32'h0);
    bus_read(2'd3, rd); check_eq("t5_tdo", rd, 32'h0);
    wait_cycles(60);
    check_eq("t5_no_more_tck", rise_count, 32'd3);

`ifdef JTAG_IRQ_EN
    // 6: irq follows done when enabled
    bus_write(2'd2, 32'h0000_0102);
    wait_cycles(15);
    check_eq("t6_irq_low_during", {31'b0, irq}, 32'h0);
    wait_cycles(1);
    check_eq("t6_irq_high", {31'b0, irq}, 32'h1);
    bus_read(2'd2, rd); check_eq("t6_status", rd, 32'h102);
    check_eq("t6_irq_cleared", {31'b0, irq}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
